// File: rtl/dlx_pkg.sv
// Shared DLX control types: sequencer state encoding and pc update commands.
package dlx_pkg;

    typedef enum logic [1:0] {
        S_FETCH = 2'b00,
        S_EXEC  = 2'b01,
        S_WB    = 2'b10,
        S_FAULT = 2'b11
    } seq_state_t;

    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_REL = 2'b10;
    localparam logic [1:0] PC_ABS = 2'b11;

    // br_kind 01 is a plain sequential step, same as 00.
    function automatic logic [1:0] map_br_kind(input logic [1:0] kind);
        logic [1:0] cmd;
        case (kind)
            PC_REL:  cmd = PC_REL;
            PC_ABS:  cmd = PC_ABS;
            default: cmd = PC_SEQ;
        endcase
        return cmd;
    endfunction

    function automatic logic is_misaligned_abs(input logic [1:0] kind, input logic [1:0] low2);
        return (kind == PC_ABS) && (low2 != 2'b00);
    endfunction

endpackage

// File: rtl/pc_sequencer_fetch_watchdog.sv
// Saturating fetch-wait counter with synchronous clear and terminal-count flag.
module fetch_watchdog #(
    parameter int FETCH_TMO = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic count_en,
    input  logic clear,
    output logic tc
);
    localparam int CW = $clog2(FETCH_TMO + 1);
    localparam logic [CW-1:0] TC_VAL  = CW'(FETCH_TMO - 1);
    localparam logic [CW-1:0] SAT_VAL = CW'(FETCH_TMO);

    logic [CW-1:0] cnt_r;

    // Count waiting fetch cycles; clear has priority, hold at saturation.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r <= '0;
        end else if (clear) begin
            cnt_r <= '0;
        end else if (count_en && (cnt_r != SAT_VAL)) begin
            cnt_r <= cnt_r + CW'(1);
        end
    end

    assign tc = (cnt_r == TC_VAL);

endmodule

// File: rtl/pc_sequencer.sv
// Fetch / execute / pc-writeback sequencer with fetch watchdog and misaligned-target fault.
module pc_sequencer
    import dlx_pkg::*;
#(
    parameter int AW        = 32,
    parameter int FETCH_TMO = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [AW-1:0] i_address,
    output logic          i_req,
    input  logic          i_ack,
    input  logic [AW-1:0] i_data,
    output logic [AW-1:0] instr,
    output logic          instr_valid,
    input  logic          ex_done,
    input  logic [1:0]    br_kind,
    input  logic [AW-1:0] br_value,
    input  logic          stall,
    output logic          pc_wb,
    output logic [1:0]    pc_cmd,
    output logic [AW-1:0] pc_v,
    output logic          fault
);
    seq_state_t state_r;
    seq_state_t state_next_s;
    logic       wd_count_s;
    logic       wd_clear_s;
    logic       wd_tc_s;

    // The pc value is owned and updated by the pc block; nothing here reads it.
    logic addr_unused_s;
    assign addr_unused_s = ^i_address;

    fetch_watchdog #(.FETCH_TMO(FETCH_TMO)) u_watchdog (
        .clk      (clk),
        .reset_n  (reset_n),
        .count_en (wd_count_s),
        .clear    (wd_clear_s),
        .tc       (wd_tc_s)
    );

    // Next-state and watchdog control; only a raised request can be acknowledged.
    always_comb begin
        state_next_s = state_r;
        wd_count_s   = 1'b0;
        wd_clear_s   = 1'b1;
        case (state_r)
            S_FETCH: begin
                wd_clear_s = 1'b0;
                if (i_req && i_ack) begin
                    wd_clear_s   = 1'b1;
                    state_next_s = S_EXEC;
                end else if (i_req) begin
                    if (wd_tc_s) begin
                        state_next_s = S_FAULT;
                    end else begin
                        wd_count_s = 1'b1;
                    end
                end else begin
                    state_next_s = S_FETCH;
                end
            end
            S_EXEC: begin
                if (ex_done) begin
                    if (is_misaligned_abs(br_kind, br_value[1:0])) begin
                        state_next_s = S_FAULT;
                    end else begin
                        state_next_s = S_WB;
                    end
                end else begin
                    state_next_s = S_EXEC;
                end
            end
            S_WB: begin
                if (!stall) begin
                    state_next_s = S_FETCH;
                end else begin
                    state_next_s = S_WB;
                end
            end
            S_FAULT: state_next_s = S_FAULT;
            default: state_next_s = S_FAULT;
        endcase
    end

    // State and registered outputs, all derived from the transition being taken.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= S_FETCH;
            i_req       <= 1'b0;
            instr       <= '0;
            instr_valid <= 1'b0;
            pc_wb       <= 1'b0;
            pc_cmd      <= PC_SEQ;
            pc_v        <= '0;
            fault       <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            i_req       <= (state_r == S_FETCH) && (state_next_s == S_FETCH);
            instr_valid <= (state_next_s == S_EXEC);
            pc_wb       <= (state_r == S_WB) && (state_next_s == S_FETCH);
            if ((state_r == S_FETCH) && (state_next_s == S_EXEC)) begin
                instr <= i_data;
            end
            if ((state_r == S_EXEC) && (state_next_s == S_WB)) begin
                pc_cmd <= map_br_kind(br_kind);
                pc_v   <= (map_br_kind(br_kind) == PC_SEQ) ? '0 : br_value;
            end
            if (state_next_s == S_FAULT) begin
                fault <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized transaction-level bench for pc_sequencer against a behavioural reference.
module tb_pc_sequencer;
    localparam int AW  = 32;
    localparam int TMO = 4;

    logic          clk;
    logic          reset_n;
    logic [AW-1:0] i_address;
    logic          i_req;
    logic          i_ack;
    logic [AW-1:0] i_data;
    logic [AW-1:0] instr;
    logic          instr_valid;
    logic          ex_done;
    logic [1:0]    br_kind;
    logic [AW-1:0] br_value;
    logic          stall;
    logic          pc_wb;
    logic [1:0]    pc_cmd;
    logic [AW-1:0] pc_v;
    logic          fault;

    int n_vec;
    int n_err;

    pc_sequencer #(.AW(AW), .FETCH_TMO(TMO)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_address   (i_address),
        .i_req       (i_req),
        .i_ack       (i_ack),
        .i_data      (i_data),
        .instr       (instr),
        .instr_valid (instr_valid),
        .ex_done     (ex_done),
        .br_kind     (br_kind),
        .br_value    (br_value),
        .stall       (stall),
        .pc_wb       (pc_wb),
        .pc_cmd      (pc_cmd),
        .pc_v        (pc_v),
        .fault       (fault)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: sim time exceeded, got running expected finished");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference rules for the pc update command.
    function automatic logic [1:0] ref_cmd(input logic [1:0] kind);
        if (kind == 2'b10) return 2'b10;
        if (kind == 2'b11) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [31:0] ref_v(input logic [1:0] kind, input logic [31:0] val);
        if (kind == 2'b10 || kind == 2'b11) return val;
        return 32'h0000_0000;
    endfunction

    task automatic check_all_zero(input string tag);
        check_val({tag, "_ireq"},  {31'd0, i_req}, 32'd0);
        check_val({tag, "_ivld"},  {31'd0, instr_valid}, 32'd0);
        check_val({tag, "_pcwb"},  {31'd0, pc_wb}, 32'd0);
        check_val({tag, "_fault"}, {31'd0, fault}, 32'd0);
        check_val({tag, "_instr"}, instr, 32'd0);
        check_val({tag, "_cmd"},   {30'd0, pc_cmd}, 32'd0);
        check_val({tag, "_pcv"},   pc_v, 32'd0);
    endtask

    // Assert reset away from the clock edge, check async clear, release, expect a request.
    task automatic do_reset();
        reset_n = 1'b0;
        #2;
        check_all_zero("rst");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick();
        check_val("req_after_reset", {31'd0, i_req}, 32'd1);
    endtask

    // One instruction from a raised request; precondition: i_req currently high.
    task automatic run_instr(input logic [31:0] data, input logic [1:0] kind,
                             input logic [31:0] val, input int d, input int e, input int s);
        int lat;
        logic [31:0] ev;
        logic [1:0]  ec;
        ec = ref_cmd(kind);
        ev = ref_v(kind, val);
        for (int i = 0; i < d; i++) begin
            tick();
            check_val("req_hold", {31'd0, i_req}, 32'd1);
            check_val("no_fault_wait", {31'd0, fault}, 32'd0);
        end
        i_ack = 1'b1;
        i_data = data;
        tick();
        i_ack = 1'b0;
        i_data = $urandom;
        lat = 1;
        check_val("instr", instr, data);
        check_val("ivld_exec", {31'd0, instr_valid}, 32'd1);
        check_val("req_drop", {31'd0, i_req}, 32'd0);
        for (int i = 0; i < e; i++) begin
            i_ack = 1'($urandom_range(0, 1));
            tick();
            lat++;
            check_val("instr_hold", instr, data);
            check_val("ivld_hold", {31'd0, instr_valid}, 32'd1);
        end
        i_ack = 1'b0;
        ex_done = 1'b1;
        br_kind = kind;
        br_value = val;
        tick();
        lat++;
        ex_done = 1'b0;
        br_kind = 2'($urandom);
        br_value = $urandom;
        if (kind == 2'b11 && val[1:0] != 2'b00) begin
            check_val("mis_fault", {31'd0, fault}, 32'd1);
            check_val("mis_pcwb", {31'd0, pc_wb}, 32'd0);
            check_val("mis_ireq", {31'd0, i_req}, 32'd0);
            check_val("mis_ivld", {31'd0, instr_valid}, 32'd0);
            for (int i = 0; i < 3; i++) begin
                i_ack = 1'($urandom_range(0, 1));
                ex_done = 1'($urandom_range(0, 1));
                tick();
                check_val("fault_sticky", {31'd0, fault}, 32'd1);
                check_val("fault_no_wb", {31'd0, pc_wb}, 32'd0);
                check_val("fault_no_req", {31'd0, i_req}, 32'd0);
            end
            i_ack = 1'b0;
            ex_done = 1'b0;
            do_reset();
            return;
        end
        check_val("ivld_wb", {31'd0, instr_valid}, 32'd0);
        check_val("cmd", {30'd0, pc_cmd}, {30'd0, ec});
        check_val("pcv", pc_v, ev);
        check_val("no_early_wb", {31'd0, pc_wb}, 32'd0);
        stall = 1'b1;
        for (int i = 0; i < s; i++) begin
            ex_done = 1'($urandom_range(0, 1));
            tick();
            lat++;
            check_val("stall_no_wb", {31'd0, pc_wb}, 32'd0);
            check_val("stall_cmd", {30'd0, pc_cmd}, {30'd0, ec});
            check_val("stall_pcv", pc_v, ev);
        end
        ex_done = 1'b0;
        stall = 1'b0;
        tick();
        lat++;
        check_val("pcwb", {31'd0, pc_wb}, 32'd1);
        check_val("latency", lat, 3 + e + s);
        check_val("wb_cmd", {30'd0, pc_cmd}, {30'd0, ec});
        check_val("wb_pcv", pc_v, ev);
        check_val("wb_no_req", {31'd0, i_req}, 32'd0);
        tick();
        check_val("pcwb_once", {31'd0, pc_wb}, 32'd0);
        check_val("req_next", {31'd0, i_req}, 32'd1);
    endtask

    task automatic run_timeout();
        for (int k = 1; k <= TMO; k++) begin
            tick();
            if (k < TMO) begin
                check_val("wd_wait_fault", {31'd0, fault}, 32'd0);
                check_val("wd_wait_req", {31'd0, i_req}, 32'd1);
            end else begin
                check_val("wd_fault", {31'd0, fault}, 32'd1);
                check_val("wd_req_low", {31'd0, i_req}, 32'd0);
            end
        end
        for (int i = 0; i < 3; i++) begin
            i_ack = 1'($urandom_range(0, 1));
            tick();
            check_val("wd_sticky", {31'd0, fault}, 32'd1);
        end
        i_ack = 1'b0;
        do_reset();
    endtask

    initial begin
        logic [1:0]  k;
        logic [31:0] v;
        n_vec = 0;
        n_err = 0;
        reset_n = 1'b1;
        i_address = 32'h0000_0000;
        i_ack = 1'b0;
        i_data = 32'h0000_0000;
        ex_done = 1'b0;
        br_kind = 2'b00;
        br_value = 32'h0000_0000;
        stall = 1'b0;
        #1;
        do_reset();

        run_instr(32'h2000_0001, 2'b00, 32'h1234_5678, 0, 0, 0);
        run_instr(32'h2000_0002, 2'b10, 32'hFFFF_FFF8, 0, 1, 0);
        run_instr(32'h2000_0003, 2'b11, 32'h0000_0100, 1, 0, 0);
        run_instr(32'h2000_0004, 2'b01, 32'hDEAD_BEEF, 0, 0, 4);
        run_instr(32'h2000_0005, 2'b10, 32'h0000_0006, TMO - 1, 0, 1);

        // Reset asserted mid-execute abandons the instruction.
        i_ack = 1'b1;
        i_data = 32'hCAFE_0001;
        tick();
        i_ack = 1'b0;
        check_val("pre_rst_ivld", {31'd0, instr_valid}, 32'd1);
        do_reset();
        check_val("rst_no_wb", {31'd0, pc_wb}, 32'd0);

        run_instr(32'h2000_0006, 2'b11, 32'h0000_0102, 0, 0, 0);
        run_timeout();

        for (int n = 0; n < 40; n++) begin
            k = 2'($urandom);
            v = $urandom;
            if (k == 2'b11) begin
                if ($urandom_range(0, 3) == 0) v[1:0] = 2'($urandom_range(1, 3));
                else v[1:0] = 2'b00;
            end
            if ($urandom_range(0, 9) == 0) begin
                run_timeout();
            end else begin
                run_instr($urandom, k, v, $urandom_range(0, TMO - 1),
                          $urandom_range(0, 3), $urandom_range(0, 4));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
